// File: rtl/csr_bus_master.sv
// Host command stream to CSR bus bridge: single writes and auto-incrementing read bursts.
// Define CSR_BUS_MASTER_WRITE_ECHO_EN to return a source beat for each write.
module csr_bus_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sink_stb,
  output logic              sink_ack,
  input  logic              sink_wr,
  input  logic [ADDR_W-1:0] sink_a,
  input  logic [DATA_W-1:0] sink_d,
  input  logic [LEN_W-1:0]  sink_len,
  output logic              source_stb,
  input  logic              source_ack,
  output logic              source_wr,
  output logic [ADDR_W-1:0] source_a,
  output logic [DATA_W-1:0] source_d,
  output logic              source_last,
  output logic [ADDR_W-1:0] adr,
  output logic              we,
  output logic [DATA_W-1:0] dat_w,
  input  logic [DATA_W-1:0] dat_r,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LAT, S_SEND} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [LEN_W-1:0]    r_rem;
  logic                r_wr;
  logic                r_sink_ack, r_we, r_busy;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat_w;
  logic                r_src_stb, r_src_wr, r_src_last;
  logic [ADDR_W-1:0]   r_src_a;
  logic [DATA_W-1:0]   r_src_d;
  logic                w_load_rd;
  logic                w_done;

  // dat_r is captured RD_LAT cycles after adr was registered
  assign w_load_rd = (r_state == S_ACCESS && !r_wr && RD_LAT == 1) ||
                     (r_state == S_LAT && r_cnt == 4'd1);
  assign w_done    = (r_state == S_SEND) && r_src_stb && source_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sink_stb) w_next = S_ACCESS;
      S_ACCESS: begin
        if (r_wr) begin
`ifdef CSR_BUS_MASTER_WRITE_ECHO_EN
          w_next = S_SEND;
`else
          w_next = S_IDLE;
`endif
        end else if (RD_LAT == 1) begin
          w_next = S_SEND;
        end else begin
          w_next = S_LAT;
        end
      end
      S_LAT:    if (w_load_rd) w_next = S_SEND;
      S_SEND:   if (w_done) w_next = (r_rem != '0) ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_wr       <= 1'b0;
      r_sink_ack <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_adr      <= '0;
      r_dat_w    <= '0;
      r_src_stb  <= 1'b0;
      r_src_wr   <= 1'b0;
      r_src_last <= 1'b0;
      r_src_a    <= '0;
      r_src_d    <= '0;
    end else begin
      r_sink_ack <= 1'b0;
      r_we       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sink_stb) begin
            r_sink_ack <= 1'b1;
            r_adr      <= sink_a;
            r_we       <= sink_wr;
            r_wr       <= sink_wr;
            r_dat_w    <= sink_d;
            r_rem      <= sink_wr ? '0 : sink_len;
            r_busy     <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_cnt <= 4'(RD_LAT - 1);
          if (r_wr) begin
`ifdef CSR_BUS_MASTER_WRITE_ECHO_EN
            r_src_stb  <= 1'b1;
            r_src_wr   <= 1'b1;
            r_src_last <= 1'b1;
            r_src_a    <= r_adr;
            r_src_d    <= r_dat_w;
`else
            r_busy     <= 1'b0;
`endif
          end
        end
        S_LAT: begin
          if (!w_load_rd) r_cnt <= r_cnt - 4'd1;
        end
        S_SEND: begin
          if (w_done) begin
            r_src_stb <= 1'b0;
            if (r_rem != '0) begin
              r_rem <= r_rem - LEN_W'(1);
              r_adr <= r_adr + ADDR_W'(1);
            end else begin
              r_busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (w_load_rd) begin
        r_src_stb  <= 1'b1;
        r_src_wr   <= 1'b0;
        r_src_last <= (r_rem == '0);
        r_src_a    <= r_adr;
        r_src_d    <= dat_r;
      end
    end
  end

  assign sink_ack    = r_sink_ack;
  assign adr         = r_adr;
  assign we          = r_we;
  assign dat_w       = r_dat_w;
  assign busy        = r_busy;
  assign source_stb  = r_src_stb;
  assign source_wr   = r_src_wr;
  assign source_last = r_src_last;
  assign source_a    = r_src_a;
  assign source_d    = r_src_d;

endmodule

// File: tb/tb_csr_bus_master.sv
// Bench for csr_bus_master: two instances (RD_LAT 1 and 3) against a CSR memory and beat-list model.
module tb_csr_bus_master;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         sink_stb, sink_ack, sink_wr, source_stb, source_ack, source_wr, source_last, we, busy;
  logic [1:0][AW-1:0] sink_a, source_a, adr;
  logic [1:0][DW-1:0] sink_d, source_d, dat_w, dat_r;
  logic [1:0][LW-1:0] sink_len;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_comb dat_r = {mem[adr[1]], mem[adr[0]]};

  csr_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .sink_stb(sink_stb[0]), .sink_ack(sink_ack[0]), .sink_wr(sink_wr[0]),
    .sink_a(sink_a[0]), .sink_d(sink_d[0]), .sink_len(sink_len[0]),
    .source_stb(source_stb[0]), .source_ack(source_ack[0]), .source_wr(source_wr[0]),
    .source_a(source_a[0]), .source_d(source_d[0]), .source_last(source_last[0]),
    .adr(adr[0]), .we(we[0]), .dat_w(dat_w[0]), .dat_r(dat_r[0]), .busy(busy[0]));

  csr_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .sink_stb(sink_stb[1]), .sink_ack(sink_ack[1]), .sink_wr(sink_wr[1]),
    .sink_a(sink_a[1]), .sink_d(sink_d[1]), .sink_len(sink_len[1]),
    .source_stb(source_stb[1]), .source_ack(source_ack[1]), .source_wr(source_wr[1]),
    .source_a(source_a[1]), .source_d(source_d[1]), .source_last(source_last[1]),
    .adr(adr[1]), .we(we[1]), .dat_w(dat_w[1]), .dat_r(dat_r[1]), .busy(busy[1]));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Read burst: expected beats are addresses a..a+len mod 2^AW with data from mem,
  // each source_stb exactly RD_LAT cycles after its adr appears.
  task automatic do_read(input int k, input logic [AW-1:0] a, input int len, input int bp,
                         input logic poke);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    sink_stb[k] = 1'b1; sink_wr[k] = 1'b0; sink_a[k] = a;
    sink_len[k] = LW'(len); sink_d[k] = DW'($urandom);
    @(negedge clk);
    chk("rd_ack", sink_ack[k], 1);
    chk("rd_busy", busy[k], 1);
    sink_stb[k] = poke;
    for (int i = 0; i <= len; i++) begin
      ea = AW'(a + AW'(i));
      ed = mem[ea];
      chk("rd_adr", adr[k], ea);
      chk("rd_stb_early", source_stb[k], 0);
      for (int c = 1; c < lat_of(k); c++) begin
        @(negedge clk);
        chk("rd_stb_lat", source_stb[k], 0);
        chk("rd_noack", sink_ack[k], 0);
      end
      @(negedge clk);
      chk("rd_stb", source_stb[k], 1);
      chk("rd_a", source_a[k], ea);
      chk("rd_d", source_d[k], ed);
      chk("rd_last", source_last[k], (i == len) ? 1 : 0);
      chk("rd_wr", source_wr[k], 0);
      if (i == ((len > 0) ? 1 : 0)) begin
        for (int b = 0; b < bp; b++) begin
          @(negedge clk);
          chk("bp_stb", source_stb[k], 1);
          chk("bp_a", source_a[k], ea);
          chk("bp_d", source_d[k], ed);
          chk("bp_adr", adr[k], ea);
          chk("bp_noack", sink_ack[k], 0);
        end
      end
      source_ack[k] = 1'b1;
      if (i == len) sink_stb[k] = 1'b0;
      @(negedge clk);
      source_ack[k] = 1'b0;
    end
    chk("rd_end_busy", busy[k], 0);
    chk("rd_end_stb", source_stb[k], 0);
    chk("rd_end_noack", sink_ack[k], 0);
  endtask

  task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    sink_stb[k] = 1'b1; sink_wr[k] = 1'b1; sink_a[k] = a;
    sink_d[k] = d; sink_len[k] = LW'($urandom_range(1, 5));
    @(negedge clk);
    chk("wr_ack", sink_ack[k], 1);
    chk("wr_we", we[k], 1);
    chk("wr_dat", dat_w[k], d);
    chk("wr_adr", adr[k], a);
    chk("wr_busy", busy[k], 1);
    sink_stb[k] = 1'b0;
    @(negedge clk);
    chk("wr_we_pulse", we[k], 0);
`ifdef CSR_BUS_MASTER_WRITE_ECHO_EN
    chk("wr_echo_stb", source_stb[k], 1);
    chk("wr_echo_wr", source_wr[k], 1);
    chk("wr_echo_d", source_d[k], d);
    chk("wr_echo_a", source_a[k], a);
    chk("wr_echo_last", source_last[k], 1);
    source_ack[k] = 1'b1;
    @(negedge clk);
    source_ack[k] = 1'b0;
    chk("wr_echo_busy", busy[k], 0);
    chk("wr_echo_drop", source_stb[k], 0);
`else
    chk("wr_nostb", source_stb[k], 0);
    chk("wr_idle", busy[k], 0);
    chk("wr_nowr", source_wr[k], 0);
`endif
  endtask

  initial begin
    sink_stb = '0; sink_wr = '0; sink_a = '0; sink_d = '0; sink_len = '0; source_ack = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[14'h0123] = 8'h5A;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_stb", source_stb[k], 0);
      chk("rst_ack", sink_ack[k], 0);
      chk("rst_adr", adr[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_we", we[k], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_read(0, 14'h0123, 0, 0, 1'b0);
    do_write(0, 14'h3FFF, 8'hA5);
    do_write(1, 14'h0040, 8'h3C);
    do_read(1, 14'h3FFE, 3, 10, 1'b1);
    do_read(0, 14'h3FFF, 2, 3, 1'b1);

    for (int r = 0; r < 8; r++) begin
      do_read(r % 2, AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom));
      if (r % 3 == 0) do_write(r % 2, AW'($urandom), DW'($urandom));
    end

    // reset while the RD_LAT=3 instance waits in LAT mid-burst
    @(negedge clk);
    sink_stb[1] = 1'b1; sink_wr[1] = 1'b0; sink_a[1] = 14'h0100; sink_len[1] = 8'd2;
    @(negedge clk);
    sink_stb[1] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy[1], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy[1], 0);
    chk("mid_rst_adr", adr[1], 0);
    chk("mid_rst_stb", source_stb[1], 0);
    chk("mid_rst_d", source_d[1], 0);
    chk("mid_rst_a", source_a[1], 0);
    chk("mid_rst_last", source_last[1], 0);
    chk("mid_rst_dw", dat_w[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(1, 14'h0123, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
